// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M iterative divide/remainder unit.
//   - funct3 encodings for DIV/DIVU/REM/REMU
//   - FSM state encoding
//   - signed-overflow dividend constant
package rv32m_pkg;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;

endpackage

// File: rtl/div_core_unsigned.sv
// Unsigned restoring divider datapath: one quotient bit per step.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load           latch load_dq/load_rem/divisor and rearm the counter
//   step           perform one shift/subtract iteration
//   load_dq        initial dividend/quotient register value
//   load_rem       initial partial remainder value
//   divisor        divisor magnitude
//   quot, rem      current quotient / remainder registers
//   last           counter has reached zero (final iteration this step)
module div_core_unsigned #(
  parameter int len = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [len-1:0] load_dq,
  input  logic [len-1:0] load_rem,
  input  logic [len-1:0] divisor,
  output logic [len-1:0] quot,
  output logic [len-1:0] rem,
  output logic           last
);

  localparam int CW = $clog2(len);

  logic [len-1:0] dq_q;
  logic [len-1:0] rem_q;
  logic [len-1:0] dvsr_q;
  logic [CW-1:0]  cnt_q;

  logic [len:0]   part;
  logic [len:0]   sub;
  logic           restore;

  // The shifted partial remainder is len+1 bits wide. When its top bit is
  // set it already exceeds any len-bit divisor, so the borrow of the
  // low-part subtraction only matters when that bit is clear.
  always_comb begin
    part    = {rem_q, dq_q[len-1]};
    sub     = {1'b0, part[len-1:0]} - {1'b0, dvsr_q};
    restore = sub[len] & ~part[len];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq_q   <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      dq_q   <= load_dq;
      rem_q  <= load_rem;
      dvsr_q <= divisor;
      cnt_q  <= CW'(len - 1);
    end else if (step) begin
      cnt_q <= cnt_q - 1'b1;
      if (restore) begin
        rem_q <= part[len-1:0];
        dq_q  <= {dq_q[len-2:0], 1'b0};
      end else begin
        rem_q <= sub[len-1:0];
        dq_q  <= {dq_q[len-2:0], 1'b1};
      end
    end
  end

  assign quot = dq_q;
  assign rem  = rem_q;
  assign last = (cnt_q == '0);

endmodule

// File: rtl/rv32m_div_unit.sv
// RV32M iterative divide/remainder unit (DIV, DIVU, REM, REMU).
// Restoring algorithm, one quotient bit per clock; signed operations run on
// magnitudes with a sign fix-up on the result. Divide-by-zero and signed
// overflow complete in one cycle.
// Optional build macro RV32M_DIV_EARLY_OUT_EN: when the divisor magnitude
// exceeds the dividend magnitude the result (q=0, r=dividend) is produced in
// one cycle instead of running the full iteration.
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset
//   start   request, sampled only in IDLE
//   funct3  RV32M funct3 (bit 2 ignored)
//   rs1     dividend, rs2 divisor (sampled on the accepting edge)
//   busy    high while iterating
//   done    one-cycle pulse, result valid
//   result  quotient or remainder, held until the next accepted start
module rv32m_div_unit
  import rv32m_pkg::*;
#(
  parameter int len = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2:0]     funct3,
  input  logic [len-1:0] rs1,
  input  logic [len-1:0] rs2,
  output logic           busy,
  output logic           done,
  output logic [len-1:0] result
);

  localparam logic [len-1:0] MIN_NEG = {1'b1, {(len-1){1'b0}}};

  state_t state_q, state_d;

  logic           op_rem_q, neg_quot_q, neg_rem_q, raw_q;
  logic           is_signed, sgn1, sgn2;
  logic [len-1:0] mag1, mag2;
  logic           div_zero, ovf, early, special, accept;
  logic [len-1:0] load_dq, load_rem;
  logic [len-1:0] quot, rem, sel;
  logic           last, neg;
  logic           unused_f3;

  assign unused_f3 = funct3[2];

  // Operand decode and special-case detection (only meaningful in IDLE).
  // Special cases preload the core registers with their final values, so
  // the result path is identical for every completion route.
  always_comb begin
    is_signed = ~funct3[0];
    sgn1      = is_signed & rs1[len-1];
    sgn2      = is_signed & rs2[len-1];
    mag1      = sgn1 ? -rs1 : rs1;
    mag2      = sgn2 ? -rs2 : rs2;
    div_zero  = (rs2 == '0);
    ovf       = is_signed && (rs1 == MIN_NEG) && (rs2 == '1);
`ifdef RV32M_DIV_EARLY_OUT_EN
    early     = (mag2 > mag1);
`else
    early     = 1'b0;
`endif
    special   = div_zero | ovf | early;
    load_dq   = mag1;
    load_rem  = '0;
    if (div_zero) begin
      load_dq  = '1;
      load_rem = rs1;
    end else if (ovf) begin
      load_dq  = MIN_NEG;
      load_rem = '0;
    end else if (early) begin
      load_dq  = '0;
      load_rem = rs1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = special ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_rem_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      raw_q      <= 1'b0;
    end else if (accept) begin
      op_rem_q   <= funct3[1];
      neg_quot_q <= sgn1 ^ sgn2;
      neg_rem_q  <= sgn1;
      raw_q      <= special;
    end
  end

  div_core_unsigned #(.len(len)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .step     (busy),
    .load_dq  (load_dq),
    .load_rem (load_rem),
    .divisor  (mag2),
    .quot     (quot),
    .rem      (rem),
    .last     (last)
  );

  // Special-case values are already final and bypass the sign fix-up.
  always_comb begin
    sel    = op_rem_q ? rem : quot;
    neg    = ~raw_q & (op_rem_q ? neg_rem_q : neg_quot_q);
    result = neg ? -sel : sel;
  end

endmodule

// File: tb/tb_rv32m_div_unit.sv
module tb_rv32m_div_unit;
  import rv32m_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = F3_DIVU;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy, done;
  logic [31:0] result;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t sb[$];

  rv32m_div_unit #(.len(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_bad++;
        $display("FAIL unexpected_done result=%h required=no done pulse", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        n_chk++;
        if (result !== e.res) begin
          n_bad++;
          $display("FAIL %s result=%h required=%h", e.nm, result, e.res);
        end
        n_chk++;
        if (cyc != e.cyc) begin
          n_bad++;
          $display("FAIL %s_latency done_at=%0d required=%0d", e.nm, cyc, e.cyc);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // lat: edges after the accepting edge until done is visible (32 or 0).
  task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_r, input int lat, input string nm);
    bit seen_busy;
    int k;
    @(negedge clk);
    funct3 = f;
    rs1    = a;
    rs2    = b;
    start  = 1'b1;
    @(posedge clk);
    #1;
    sb.push_back('{exp_r, cyc + lat, nm});
    start = 1'b0;
    rs1   = $urandom;
    rs2   = $urandom;
    seen_busy = 1'b0;
    k = 0;
    while (sb.size() != 0 && k < 60) begin
      @(negedge clk);
      #1;
      if (busy) seen_busy = 1'b1;
      k++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_bad++;
      $display("FAIL %s_timeout done_seen=0 required=1", nm);
      sb.delete();
    end
    check({nm, "_busy"}, {31'b0, seen_busy}, {31'b0, (lat != 0)});
    @(negedge clk);
    check({nm, "_hold"}, result, exp_r);
  endtask

  int eo_lat;

  initial begin
`ifdef RV32M_DIV_EARLY_OUT_EN
    eo_lat = 0;
`else
    eo_lat = 32;
`endif
    repeat (2) @(negedge clk);
    check("reset_busy",   {31'b0, busy}, 32'd0);
    check("reset_done",   {31'b0, done}, 32'd0);
    check("reset_result", result,        32'd0);
    rst = 1'b0;

    run(F3_DIVU, 32'd100,        32'd7,          32'd14,         32, "divu_100_7");
    run(F3_REMU, 32'd100,        32'd7,          32'd2,          32, "remu_100_7");
    run(F3_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32, "div_m7_2");
    run(F3_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32, "rem_m7_2");
    run(F3_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32, "div_7_m2");
    run(F3_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          32, "rem_7_m2");
    run(F3_DIV,  32'hFFFF_FFF8,  32'hFFFF_FFFE,  32'd4,          32, "div_m8_m2");
    run(3'b001,  32'hFFFF_FFFF,  32'h8000_0001,  32'd1,          32, "divu_big_f3b2");
    run(F3_REMU, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  32, "remu_big");
    run(F3_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  0,  "divu_by0");
    run(F3_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  0,  "rem_by0");
    run(F3_DIV,  OVF_DIVIDEND,   32'hFFFF_FFFF,  32'h8000_0000,  0,  "div_ovf");
    run(F3_REM,  OVF_DIVIDEND,   32'hFFFF_FFFF,  32'd0,          0,  "rem_ovf");
    run(F3_DIVU, 32'd3,          32'd10,         32'd0,          eo_lat, "divu_3_10");
    run(F3_REMU, 32'd3,          32'd10,         32'd3,          eo_lat, "remu_3_10");

    // Abort: long divide, ignored second start, then reset mid-iteration.
    @(negedge clk);
    funct3 = F3_DIVU;
    rs1    = 32'd1000;
    rs2    = 32'd3;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(negedge clk);
    funct3 = F3_REMU;
    rs1    = 32'd50;
    rs2    = 32'd5;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_during_calc", {31'b0, busy}, 32'd1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy",   {31'b0, busy}, 32'd0);
    check("abort_done",   {31'b0, done}, 32'd0);
    check("abort_result", result,        32'd0);
    @(negedge clk);
    rst = 1'b0;
    run(F3_DIVU, 32'd9, 32'd3, 32'd3, 32, "divu_9_3_after_rst");

    repeat (40) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog elapsed=1 required=0");
    $fatal(1, "watchdog");
  end

endmodule
